// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry {instr, pc} queue.
// Optional FETCH_MISALIGN_CHK_EN flags redirect targets whose low two bits are non-zero.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [1:0]  count;
    logic [31:0] e0_instr, e0_pc;
    logic [31:0] e1_instr, e1_pc;

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] target;

    assign target = redirect_pc & ~32'd3;

    // A request is only issued when the queue can absorb its response.
    assign imem_req    = rst_n && (state == FETCH) && (count != 2'd2) && !redirect;
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign push        = (state == WAIT) && imem_rvalid && !redirect;
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr       = e0_instr;
    assign instr_pc    = e0_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            case (state)
                FETCH:   if (accept) state <= WAIT;
                WAIT: begin
                    if (imem_rvalid)   state <= FETCH;
                    else if (redirect) state <= DISCARD;
                end
                DISCARD: if (imem_rvalid) state <= FETCH;
                default: state <= FETCH;
            endcase

            if (redirect) begin
                pc <= target;
            end else if (accept) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            e0_instr <= '0;
            e0_pc    <= '0;
            e1_instr <= '0;
            e1_pc    <= '0;
        end else if (redirect) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Simultaneous push/pop: shift and refill so occupancy is unchanged.
                    if (count == 2'd2) begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                        e1_instr <= imem_rdata;
                        e1_pc    <= req_pc;
                    end else begin
                        e0_instr <= imem_rdata;
                        e0_pc    <= req_pc;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_instr <= imem_rdata;
                        e0_pc    <= req_pc;
                    end else begin
                        e1_instr <= imem_rdata;
                        e1_pc    <= req_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0_instr <= e1_instr;
                    e0_pc    <= e1_pc;
                    count    <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; the PC loaded at reset.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts the request this cycle when imem_req&imem_ready.
- imem_rvalid  in  1  read data valid, in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump taken; refetch from redirect_pc.
- redirect_pc  in  32  new fetch target.
- instr_valid  out  1  head entry valid toward decode.
- instr_ready  in  1  decode consumes head when instr_valid&instr_ready.
- instr  out  32  head instruction; decode slices [31:7] to the immediate extender.
- instr_pc  out  32  PC of head instruction.
- misalign_err  out  1  one-cycle pulse on misaligned redirect target.

Function
REQ-003 SHALL hold a 2-entry FIFO of {instr, pc}; instr/instr_pc SHALL come from registered head, never combinationally from imem_rdata.
REQ-004 SHALL allow at most one outstanding memory request.
REQ-005 SHALL assert imem_req only when no request is outstanding and FIFO occupancy + 0 < 2 (a free slot exists for the response).
REQ-006 imem_addr SHALL equal the fetch PC register; fetch PC SHALL advance by 4 on each accepted request (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-007 FSM states: FETCH (may request), WAIT (one outstanding, response kept), DISCARD (one outstanding, response dropped).
REQ-008 FETCH->WAIT on accepted request; WAIT->FETCH on imem_rvalid; DISCARD->FETCH on imem_rvalid.
REQ-009 A WAIT response SHALL be written to the FIFO tail with the PC of its request; instr_valid SHALL rise the cycle after imem_rvalid.
REQ-010 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-011 redirect SHALL, in that cycle: flush FIFO (instr_valid 0 next cycle), load fetch PC with {redirect_pc[31:2],2'b00}, and ignore any concurrent pop.
REQ-012 redirect while WAIT, or coincident with an accepted request, SHALL enter DISCARD; redirect coincident with imem_rvalid in WAIT SHALL drop that data and enter FETCH.
REQ-013 redirect while in DISCARD SHALL update fetch PC and remain in DISCARD until the pending response arrives.
REQ-014 imem_req SHALL not assert in the redirect cycle; fetching from the new PC starts the next cycle at earliest.
REQ-015 imem_rvalid in FETCH (no outstanding) SHALL be ignored.

Reset
REQ-016 rst_n low SHALL asynchronously force: state FETCH, fetch PC RESET_PC, FIFO empty, instr_valid 0, instr 0, instr_pc 0, imem_req 0, misalign_err 0.
REQ-017 First imem_req SHALL assert in the first clock after rst_n deasserts; a response arriving after a mid-operation reset SHALL be ignored per REQ-015.

Configuration
REQ-018 Macro FETCH_MISALIGN_CHK_EN: defined -> misalign_err pulses high one cycle after a redirect with redirect_pc[1:0]!=0, target still aligned per REQ-011; undefined -> misalign_err tied 0, low bits silently cleared.

Verification
REQ-019 Reset release, imem_ready=1, 1-cycle memory latency, instr_ready=1 -> addresses 0,4,8 issued; instr/instr_pc sequence matches rdata and PCs in order.
REQ-020 instr_ready=0 for 10 cycles -> exactly 2 entries held, imem_req low; release -> entries drain in order, no loss/duplication.
REQ-021 redirect to 32'h100 while WAIT for PC 8 -> PC 8 data dropped, next delivered instr_pc=32'h100, then 32'h104.
REQ-022 redirect coincident with imem_rvalid and instr_ready -> FIFO empty next cycle, rdata not delivered, next imem_addr=redirect target.
REQ-023 With FETCH_MISALIGN_CHK_EN, redirect_pc=32'h202 -> misalign_err one-cycle pulse, imem_addr=32'h200; without macro -> misalign_err stays 0.
REQ-024 Fetch PC 32'hFFFF_FFFC accepted -> next imem_addr=32'h0; rst_n low mid-WAIT -> all outputs at reset values immediately, late rvalid ignored.
